// File: rtl/fegx_pkg.sv
// Shared encodings and widths for the ALU write-back stage.
// Used by alu_writeback and wb_flag_reg.
package fegx_pkg;

    localparam int DATA_W  = 8;
    localparam int RADDR_W = 3;
    localparam int DADDR_W = 8;
    localparam int RCNT_W  = 16;

    typedef enum logic [2:0] {
        CMD_LDST_MOV = 3'b000,
        CMD_IMM      = 3'b001,
        CMD_AND      = 3'b010,
        CMD_OR       = 3'b011,
        CMD_XOR      = 3'b100,
        CMD_SLL      = 3'b101,
        CMD_SRL      = 3'b110,
        CMD_BR       = 3'b111
    } alu_cmd_t;

    typedef enum logic [1:0] {
        SEL_LDR = 2'b00,
        SEL_STR = 2'b01,
        SEL_MOV = 2'b10,
        SEL_RSV = 2'b11
    } sel_cmd_t;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WRITE = 2'd1,
        WB_STORE = 2'd2
    } wb_state_t;

    // A store is the load/store/move command with the STR sub-select.
    function automatic logic is_store(input logic [2:0] cmd, input logic [1:0] sel);
        return (cmd == CMD_LDST_MOV) && (sel == SEL_STR);
    endfunction

endpackage

// File: rtl/wb_flag_reg.sv
// Architectural flag register with per-command update-enable decoding.
// Zero/parity update for commands AND..SRL, carry only for the shifts.
module wb_flag_reg
    import fegx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_accept,
    input  logic [2:0] i_alu_cmd,
    input  logic       i_zero,
    input  logic       i_pari,
    input  logic       i_sc_o,
    output logic       o_flag_zero,
    output logic       o_flag_pari,
    output logic       o_flag_sc
);

    logic w_upd_zp;
    logic w_upd_sc;
    logic r_flag_zero;
    logic r_flag_pari;
    logic r_flag_sc;

    always_comb begin
        w_upd_zp = 1'b0;
        w_upd_sc = 1'b0;
        if (i_accept) begin
            w_upd_zp = (i_alu_cmd >= CMD_AND) && (i_alu_cmd <= CMD_SRL);
            w_upd_sc = (i_alu_cmd == CMD_SLL) || (i_alu_cmd == CMD_SRL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flag_zero <= 1'b0;
            r_flag_pari <= 1'b0;
            r_flag_sc   <= 1'b0;
        end else begin
            if (w_upd_zp) begin
                r_flag_zero <= i_zero;
                r_flag_pari <= i_pari;
            end
            if (w_upd_sc) begin
                r_flag_sc <= i_sc_o;
            end
        end
    end

    assign o_flag_zero = r_flag_zero;
    assign o_flag_pari = r_flag_pari;
    assign o_flag_sc   = r_flag_sc;

endmodule

// File: rtl/alu_writeback.sv
// ALU write-back stage: one-entry buffer, IDLE/WRITE/STORE FSM, flag register.
// Optional retired-instruction counter enabled by defining ALU_WB_RETIRE_CNT_EN.
module alu_writeback
    import fegx_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alu_cmd,
    input  logic [1:0]         sel_cmd,
    input  logic [DATA_W-1:0]  rslt,
    input  logic               sc_o,
    input  logic               pari,
    input  logic               zero,
    input  logic               wr_en,
    input  logic [RADDR_W-1:0] waddr,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               dm_req,
    output logic [DADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0]  dm_wdata,
    input  logic               dm_ack,
    output logic               flag_zero,
    output logic               flag_pari,
    output logic               flag_sc,
    output logic               sc_i
`ifdef ALU_WB_RETIRE_CNT_EN
    ,
    output logic [RCNT_W-1:0]  retire_cnt
`endif
);

    wb_state_t          r_state;
    wb_state_t          w_state_nxt;
    logic [DATA_W-1:0]  r_rslt;
    logic [RADDR_W-1:0] r_waddr;
    logic [2:0]         r_alu_cmd;
    logic [1:0]         r_sel_cmd;
    logic               r_wr_en;

    logic w_accept;
    logic w_in_store;
    logic w_buf_store;

    assign in_ready    = (r_state == WB_IDLE) && !reset;
    assign w_accept    = in_valid && in_ready;
    assign w_in_store  = is_store(alu_cmd, sel_cmd);
    assign w_buf_store = is_store(r_alu_cmd, r_sel_cmd);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WB_IDLE: begin
                if (w_accept) begin
                    if (w_in_store) begin
                        w_state_nxt = WB_STORE;
                    end else if (wr_en) begin
                        w_state_nxt = WB_WRITE;
                    end
                end
            end
            WB_WRITE: begin
                w_state_nxt = WB_IDLE;
            end
            WB_STORE: begin
                if (dm_ack) begin
                    w_state_nxt = WB_IDLE;
                end
            end
            default: begin
                w_state_nxt = WB_IDLE;
            end
        endcase
    end

    // The buffer only loads in IDLE, so it stays stable for a whole WRITE/STORE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= WB_IDLE;
            r_rslt    <= '0;
            r_waddr   <= '0;
            r_alu_cmd <= '0;
            r_sel_cmd <= '0;
            r_wr_en   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rslt    <= rslt;
                r_waddr   <= waddr;
                r_alu_cmd <= alu_cmd;
                r_sel_cmd <= sel_cmd;
                r_wr_en   <= wr_en;
            end
        end
    end

    // Qualifying each strobe with the buffered command keeps them mutually exclusive.
    assign rf_we    = (r_state == WB_WRITE) && r_wr_en && !w_buf_store;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_rslt;
    assign dm_req   = (r_state == WB_STORE) && w_buf_store;
    assign dm_addr  = {{(DADDR_W-RADDR_W){1'b0}}, r_waddr};
    assign dm_wdata = r_rslt;

    wb_flag_reg u_flag_reg (
        .clk         (clk),
        .reset       (reset),
        .i_accept    (w_accept),
        .i_alu_cmd   (alu_cmd),
        .i_zero      (zero),
        .i_pari      (pari),
        .i_sc_o      (sc_o),
        .o_flag_zero (flag_zero),
        .o_flag_pari (flag_pari),
        .o_flag_sc   (flag_sc)
    );

    assign sc_i = flag_sc;

`ifdef ALU_WB_RETIRE_CNT_EN
    logic              w_retire;
    logic [RCNT_W-1:0] r_retire_cnt;

    // Retire on WRITE exit, acknowledged store, or an accept that stays in IDLE.
    assign w_retire = (r_state == WB_WRITE)
                    || ((r_state == WB_STORE) && dm_ack)
                    || (w_accept && !w_in_store && !wr_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized self-checking bench for alu_writeback against a transaction-level model.
// Counter checks are compiled in when ALU_WB_RETIRE_CNT_EN is defined.
module tb_alu_writeback;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] alu_cmd;
    logic [1:0] sel_cmd;
    logic [7:0] rslt;
    logic       sc_o;
    logic       pari;
    logic       zero;
    logic       wr_en;
    logic [2:0] waddr;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       dm_req;
    logic [7:0] dm_addr;
    logic [7:0] dm_wdata;
    logic       dm_ack;
    logic       flag_zero;
    logic       flag_pari;
    logic       flag_sc;
    logic       sc_i;
`ifdef ALU_WB_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    alu_writeback dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_cmd   (alu_cmd),
        .sel_cmd   (sel_cmd),
        .rslt      (rslt),
        .sc_o      (sc_o),
        .pari      (pari),
        .zero      (zero),
        .wr_en     (wr_en),
        .waddr     (waddr),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .dm_req    (dm_req),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .flag_zero (flag_zero),
        .flag_pari (flag_pari),
        .flag_sc   (flag_sc),
        .sc_i      (sc_i)
`ifdef ALU_WB_RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a pending register write, a pending store, flags, counter.
    logic        m_wr_pend;
    logic        m_st_pend;
    logic [2:0]  m_addr;
    logic [7:0]  m_data;
    logic        m_fz;
    logic        m_fp;
    logic        m_fs;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr_pend = 1'b0;
        m_st_pend = 1'b0;
        m_addr    = 3'd0;
        m_data    = 8'd0;
        m_fz      = 1'b0;
        m_fp      = 1'b0;
        m_fs      = 1'b0;
        m_cnt     = 16'd0;
    endtask

    task automatic check_outputs();
        logic exp_ready;
        exp_ready = !m_wr_pend && !m_st_pend && !reset;
        chk("in_ready", in_ready, exp_ready);
        chk("rf_we", rf_we, m_wr_pend);
        chk("dm_req", dm_req, m_st_pend);
        chk("rf_waddr", rf_waddr, m_addr);
        chk("rf_wdata", rf_wdata, m_data);
        chk("dm_addr", dm_addr, {5'd0, m_addr});
        chk("dm_wdata", dm_wdata, m_data);
        chk("flag_zero", flag_zero, m_fz);
        chk("flag_pari", flag_pari, m_fp);
        chk("flag_sc", flag_sc, m_fs);
        chk("sc_i", sc_i, m_fs);
`ifdef ALU_WB_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, m_cnt);
`endif
    endtask

    task automatic model_step();
        logic ready;
        logic store;
        ready = !m_wr_pend && !m_st_pend;
        store = (alu_cmd == 3'd0) && (sel_cmd == 2'd1);
        if (reset) begin
            model_reset();
        end else if (m_wr_pend) begin
            m_wr_pend = 1'b0;
            m_cnt     = m_cnt + 16'd1;
        end else if (m_st_pend) begin
            if (dm_ack) begin
                m_st_pend = 1'b0;
                m_cnt     = m_cnt + 16'd1;
            end
        end else if (ready && in_valid) begin
            m_addr = waddr;
            m_data = rslt;
            if (store) m_st_pend = 1'b1;
            else if (wr_en) m_wr_pend = 1'b1;
            else m_cnt = m_cnt + 16'd1;
            if (alu_cmd >= 3'd2 && alu_cmd <= 3'd6) begin
                m_fz = zero;
                m_fp = pari;
            end
            if (alu_cmd == 3'd5 || alu_cmd == 3'd6) m_fs = sc_o;
        end
    endtask

    // Drive one cycle of inputs, check against the model mid-cycle, advance past the edge.
    task automatic cycle(input logic v, input logic [2:0] cmd, input logic [1:0] sel,
                         input logic [7:0] rs, input logic sco, input logic pa, input logic ze,
                         input logic we, input logic [2:0] wa, input logic ack, input logic rst);
        in_valid = v;
        alu_cmd  = cmd;
        sel_cmd  = sel;
        rslt     = rs;
        sc_o     = sco;
        pari     = pa;
        zero     = ze;
        wr_en    = we;
        waddr    = wa;
        dm_ack   = ack;
        reset    = rst;
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 3'd0, 2'd0, 8'd0, 0, 0, 0, 0, 3'd0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; alu_cmd = 3'd0; sel_cmd = 2'd0; rslt = 8'd0;
        sc_o = 1'b0; pari = 1'b0; zero = 1'b0; wr_en = 1'b0; waddr = 3'd0; dm_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_dm_req", dm_req, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_dm_wdata", dm_wdata, 0);
        chk("rst_flags", {flag_zero, flag_pari, flag_sc}, 3'b000);

        // Write after reset
        idle(1);
        chk("idle_ready", in_ready, 1);
        cycle(1, 3'b010, 2'd0, 8'h5A, 0, 0, 0, 1, 3'd3, 0, 0);
        chk("wr_rf_we", rf_we, 1);
        chk("wr_rf_waddr", rf_waddr, 3);
        chk("wr_rf_wdata", rf_wdata, 8'h5A);
        chk("wr_in_ready", in_ready, 0);
        idle(1);
        chk("wr_done_ready", in_ready, 1);
        chk("wr_done_rf_we", rf_we, 0);

        // Store with ack held off for three cycles
        cycle(1, 3'b000, 2'b01, 8'hC3, 0, 0, 0, 0, 3'd5, 0, 0);
        chk("st_req", dm_req, 1);
        chk("st_addr", dm_addr, 8'h05);
        chk("st_data", dm_wdata, 8'hC3);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 3'd0, 2'd0, 8'd0, 0, 0, 0, 0, 3'd0, 0, 0);
            chk("st_hold_req", dm_req, 1);
            chk("st_hold_addr", dm_addr, 8'h05);
            chk("st_hold_data", dm_wdata, 8'hC3);
            chk("st_hold_rf_we", rf_we, 0);
        end
        cycle(0, 3'd0, 2'd0, 8'd0, 0, 0, 0, 0, 3'd0, 1, 0);
        chk("st_ack_drop", dm_req, 0);
        chk("st_ack_ready", in_ready, 1);

        // Flag updates: SLL then AND
        cycle(1, 3'b101, 2'd0, 8'h00, 1, 0, 1, 0, 3'd0, 0, 0);
        chk("sll_flags", {flag_zero, flag_pari, flag_sc}, 3'b101);
        cycle(1, 3'b010, 2'd0, 8'h07, 0, 1, 0, 0, 3'd0, 0, 0);
        chk("and_flags", {flag_zero, flag_pari, flag_sc}, 3'b011);
        chk("and_sc_i", sc_i, 1);
        cycle(1, 3'b111, 2'd0, 8'h00, 0, 0, 1, 0, 3'd0, 0, 0);
        chk("br_flags", {flag_zero, flag_pari, flag_sc}, 3'b011);

        // Reset in the second store cycle with a simultaneous ack
        cycle(1, 3'b000, 2'b01, 8'h11, 0, 0, 0, 0, 3'd2, 0, 0);
        cycle(0, 3'd0, 2'd0, 8'd0, 0, 0, 0, 0, 3'd0, 0, 0);
        cycle(0, 3'd0, 2'd0, 8'd0, 0, 0, 0, 0, 3'd0, 1, 1);
        chk("rst_st_req", dm_req, 0);
        chk("rst_st_flags", {flag_zero, flag_pari, flag_sc}, 3'b000);
        chk("rst_st_ready", in_ready, 0);
        chk("rst_st_addr", dm_addr, 8'h00);
`ifdef ALU_WB_RETIRE_CNT_EN
        chk("rst_st_cnt", retire_cnt, 0);
`endif
        idle(1);
        chk("post_rst_ready", in_ready, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [2:0] c;
            logic [1:0] s;
            c = 3'($urandom_range(0, 7));
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                c = 3'd0;
                s = 2'd1;
            end
            cycle(1'($urandom_range(0, 3) != 0), c, s, 8'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 49) == 0));
        end

`ifdef ALU_WB_RETIRE_CNT_EN
        // Counter wrap, then a held write request
        cycle(0, 3'd0, 2'd0, 8'd0, 0, 0, 0, 0, 3'd0, 0, 1);
        for (int i = 0; i < 65535; i++) cycle(1, 3'b001, 2'd0, 8'h01, 0, 0, 0, 0, 3'd1, 0, 0);
        chk("cnt_full", retire_cnt, 16'hFFFF);
        cycle(1, 3'b001, 2'd0, 8'h01, 0, 0, 0, 0, 3'd1, 0, 0);
        chk("cnt_wrap", retire_cnt, 16'h0000);
        cycle(1, 3'b011, 2'd0, 8'h22, 0, 0, 0, 1, 3'd4, 0, 0);
        chk("held_wr_cnt0", retire_cnt, 16'h0000);
        cycle(1, 3'b011, 2'd0, 8'h22, 0, 0, 0, 1, 3'd4, 0, 0);
        chk("held_wr_cnt1", retire_cnt, 16'h0001);
        chk("held_wr_rf_we", rf_we, 0);
        chk("held_wr_ready", in_ready, 1);
        idle(2);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 The block SHALL have a `clk` input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have a `reset` input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have an `in_valid` input, 1 bit: ALU result and sidebands present this cycle.
REQ-004 The block SHALL have an `in_ready` output, 1 bit: block accepts this cycle.
REQ-005 The block SHALL have an `alu_cmd` input, 3 bits: ALU command of the instruction.
REQ-006 The block SHALL have a `sel_cmd` input, 2 bits: ALU sub-select of the instruction.
REQ-007 The block SHALL have inputs `rslt` (8 bits), `sc_o` (1 bit), `pari` (1 bit) and `zero` (1 bit): ALU outputs.
REQ-008 The block SHALL have a `wr_en` input, 1 bit: the instruction writes the register file.
REQ-009 The block SHALL have a `waddr` input, 3 bits: destination register or store address.
REQ-010 The block SHALL have outputs `rf_we` (1 bit), `rf_waddr` (3 bits) and `rf_wdata` (8 bits): register-file write port.
REQ-011 The block SHALL have outputs `dm_req` (1 bit), `dm_addr` (8 bits) and `dm_wdata` (8 bits), and an input `dm_ack` (1 bit): data-memory store handshake.
REQ-012 The block SHALL have outputs `flag_zero`, `flag_pari` and `flag_sc`, 1 bit each: architectural flag register.
REQ-013 The block SHALL have an output `sc_i`, 1 bit: carry fed back to the ALU, equal to `flag_sc`.
REQ-014 The block SHALL have an output `retire_cnt`, 16 bits, present only under `ALU_WB_RETIRE_CNT_EN`.

Function
REQ-015 The FSM SHALL have the states IDLE, WRITE and STORE; `in_ready` = 1 only in IDLE.
REQ-016 Accept SHALL occur when `in_valid` && `in_ready`; on accept the block SHALL latch `rslt`, `waddr`, `alu_cmd`, `sel_cmd` and `wr_en` into a one-entry buffer.
REQ-017 Store instructions (`alu_cmd` = 000, `sel_cmd` = 01) SHALL go IDLE->STORE on accept, else if `wr_en`=1 IDLE->WRITE, else remain in IDLE.
REQ-018 WRITE SHALL last exactly one cycle:
- `rf_we` = 1, `rf_waddr`/`rf_wdata` = latched values;
- next state IDLE.
- Latency: accept in cycle N -> `rf_we` in cycle N+1.
REQ-019 In STORE, `dm_req` SHALL be 1, `dm_addr` = zero-extended latched `waddr` and `dm_wdata` = latched `rslt`, all held stable until `dm_ack`.
REQ-020 A `dm_ack` sampled high in STORE SHALL cause STORE->IDLE at that edge; `dm_req` = 0 the next cycle.
REQ-021 `dm_ack` outside STORE SHALL be ignored.
REQ-022 Flags SHALL update only on accept:
- `flag_zero` and `flag_pari` for `alu_cmd` 010..110;
- `flag_sc` only for 101/110;
- all other commands leave the flags unchanged.
REQ-023 Flags SHALL reflect the new value from cycle N+1; `sc_i` follows `flag_sc` combinationally.
REQ-024 `in_valid` while `in_ready` = 0 SHALL be ignored; the upstream stage holds its data.
REQ-025 Sustained throughput SHALL be one instruction per cycle for flag-only instructions, and one per two cycles for writes.
REQ-026 `rf_we` and `dm_req` SHALL never be asserted in the same cycle.

Reset
REQ-027 `reset` sampled high SHALL force, at that edge:
- state IDLE;
- `rf_we`, `dm_req` and all flags to 0;
- `rf_waddr`, `rf_wdata`, `dm_addr` and `dm_wdata` to 0;
- `retire_cnt` to 0.
REQ-028 Reset during STORE SHALL abandon the store; a `dm_ack` in the reset cycle SHALL be ignored.
REQ-029 `in_ready` SHALL be 0 during a reset cycle and 1 in the first cycle after it.

Configuration
REQ-030 With `ALU_WB_RETIRE_CNT_EN` defined, `retire_cnt` SHALL increment by 1 on each of:
- WRITE exit;
- STORE exit on `dm_ack`;
- flag-only accept.
It SHALL wrap from 0xFFFF to 0x0000.
REQ-031 Without `ALU_WB_RETIRE_CNT_EN`, neither the port nor the counter logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-032 The shared package `fegx_pkg` SHALL hold:
- the `alu_cmd` encodings as an enum (000 LDR/STR/MOV … 111 br);
- the `sel_cmd` encodings;
- the `wb_state_t` enum;
- the widths DATA_W = 8 and RADDR_W = 3.
REQ-033 The flag register and its update-enable decoding SHALL be a sub-module `wb_flag_reg`; the FSM and buffer SHALL stay in `alu_writeback`.

Verification
REQ-034 Write, reset then IDLE: accept `alu_cmd` = 010, `rslt` = 0x5A, `wr_en` = 1, `waddr` = 3 -> next cycle `rf_we` = 1, `rf_waddr` = 3, `rf_wdata` = 0x5A, `in_ready` = 0; the following cycle `in_ready` = 1.
REQ-035 Store with delayed ack: accept `alu_cmd` = 000, `sel_cmd` = 01, `rslt` = 0xC3, `waddr` = 5; `dm_ack` low for 3 cycles -> `dm_req` = 1, `dm_addr` = 0x05, `dm_wdata` = 0xC3 stable for 4 cycles, dropping the cycle after the ack.
REQ-036 Flag update: accept SLL with `rslt` = 0x00 and `sc_o` = 1, then AND with `rslt` = 0x07 and `sc_o` = 0 -> flags = {zero 1, pari 0, sc 1}, then {zero 0, pari 1, sc 1}, with `sc_i` = 1.
REQ-037 Reset in the middle of a store: assert `reset` in the 2nd STORE cycle together with `dm_ack` = 1 -> `dm_req` = 0 next cycle, state IDLE, flags 0, `retire_cnt` = 0.
REQ-038 Counter wrap (with the macro defined): preload via 65535 flag-only accepts, then one more -> `retire_cnt` reads 0x0000; held `in_valid` during WRITE is not double-accepted.
